// File: rtl/writeback_arbiter.sv
// Writeback arbiter: per-source FIFOs drained one entry per cycle into the register-file write port.
// Define WRITEBACK_FIXED_PRIORITY_EN for lowest-index-first arbitration instead of round-robin.
module writeback_arbiter #(
    parameter int DATABITWIDTH    = 16,
    parameter int REGADDRBITWIDTH = 4,
    parameter int SOURCECOUNT     = 4,
    parameter int BUFFERDEPTH     = 2
) (
    input  logic                                   clk,
    input  logic                                   clk_en,
    input  logic                                   sync_rst,
    input  logic [SOURCECOUNT-1:0]                 Src_Valid,
    input  logic [SOURCECOUNT*REGADDRBITWIDTH-1:0] Src_Addr,
    input  logic [SOURCECOUNT*DATABITWIDTH-1:0]    Src_Data,
    output logic [SOURCECOUNT-1:0]                 Src_Ready,
    output logic                                   Write_En,
    output logic [REGADDRBITWIDTH-1:0]             Write_Address,
    output logic [DATABITWIDTH-1:0]                Write_Data,
    output logic                                   Forward1Valid,
    output logic [REGADDRBITWIDTH-1:0]             Forward1RegAddr,
    output logic [DATABITWIDTH-1:0]                Forward1Data,
    output logic                                   WritebackCongestion,
    output logic                                   WritebackIdle
);

    localparam int IW = $clog2(SOURCECOUNT);
    localparam int PW = $clog2(BUFFERDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(BUFFERDEPTH);
    localparam logic [IW-1:0] LAST_SRC = IW'(SOURCECOUNT - 1);

    logic [SOURCECOUNT-1:0]     empty;
    logic [SOURCECOUNT-1:0]     full;
    logic [SOURCECOUNT-1:0]     push;
    logic [SOURCECOUNT-1:0]     pop;
    logic [REGADDRBITWIDTH-1:0] head_addr [SOURCECOUNT];
    logic [DATABITWIDTH-1:0]    head_data [SOURCECOUNT];

    logic          gnt_valid;
    logic [IW-1:0] gnt_idx;
    logic [IW-1:0] cand;

    logic                       wr_en_q;
    logic                       wr_en_d;
    logic [REGADDRBITWIDTH-1:0] wr_addr_q;
    logic [REGADDRBITWIDTH-1:0] wr_addr_d;
    logic [DATABITWIDTH-1:0]    wr_data_q;
    logic [DATABITWIDTH-1:0]    wr_data_d;

    for (genvar g = 0; g < SOURCECOUNT; g++) begin : g_fifo
        logic [REGADDRBITWIDTH-1:0] addr_mem_q [BUFFERDEPTH];
        logic [DATABITWIDTH-1:0]    data_mem_q [BUFFERDEPTH];
        logic [PW-1:0]              wr_ptr_q;
        logic [PW-1:0]              wr_ptr_d;
        logic [PW-1:0]              rd_ptr_q;
        logic [PW-1:0]              rd_ptr_d;
        logic [CW-1:0]              count_q;
        logic [CW-1:0]              count_d;

        // Readiness comes from registered occupancy only: no pass-through.
        assign full[g]      = (count_q == FULL_CNT);
        assign empty[g]     = (count_q == '0);
        assign push[g]      = Src_Valid[g] & ~full[g];
        assign pop[g]       = gnt_valid && (gnt_idx == IW'(g));
        assign head_addr[g] = addr_mem_q[rd_ptr_q];
        assign head_data[g] = data_mem_q[rd_ptr_q];

        always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            count_d  = count_q;
            if (push[g]) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop[g])  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push[g] && !pop[g]) begin
                count_d = count_q + CW'(1);
            end else if (!push[g] && pop[g]) begin
                count_d = count_q - CW'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (sync_rst) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else if (clk_en) begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                count_q  <= count_d;
            end
        end

        always_ff @(posedge clk) begin
            if (clk_en && !sync_rst && push[g]) begin
                addr_mem_q[wr_ptr_q] <=
                    Src_Addr[g*REGADDRBITWIDTH +: REGADDRBITWIDTH];
                data_mem_q[wr_ptr_q] <=
                    Src_Data[g*DATABITWIDTH +: DATABITWIDTH];
            end
        end
    end

`ifndef WRITEBACK_FIXED_PRIORITY_EN
    logic [IW-1:0] rr_ptr_q;
    logic [IW-1:0] rr_ptr_d;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt_valid) begin
            rr_ptr_d = (gnt_idx == LAST_SRC) ? '0 : gnt_idx + IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            rr_ptr_q <= '0;
        end else if (clk_en) begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    // Scan downwards so the closest candidate to the start point wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = SOURCECOUNT - 1; k >= 0; k--) begin
`ifdef WRITEBACK_FIXED_PRIORITY_EN
            cand = IW'(k);
`else
            cand = IW'((int'(rr_ptr_q) + k) % SOURCECOUNT);
`endif
            if (!empty[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        wr_en_d   = gnt_valid;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (gnt_valid) begin
            wr_addr_d = head_addr[gnt_idx];
            wr_data_d = head_data[gnt_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else if (clk_en) begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign Src_Ready           = ~full;
    assign Write_En            = wr_en_q;
    assign Write_Address       = wr_addr_q;
    assign Write_Data          = wr_data_q;
    assign Forward1Valid       = wr_en_q;
    assign Forward1RegAddr     = wr_addr_q;
    assign Forward1Data        = wr_data_q;
    assign WritebackCongestion = |full;
    assign WritebackIdle       = (&empty) & ~wr_en_q;

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Shares the register file's single write port (Write_En/Write_Address/Write_Data) among up to SOURCECOUNT execute-stage result producers: ALU0, ALU1, branch link and long-latency units.
- Each source has a small per-source FIFO. A round-robin arbiter drains one entry per enabled cycle into a registered write port.
- The same registered write port also drives the Forward1 inputs of the forwarding system.
- Asserts a congestion signal toward stall control when any source FIFO is full.

Parameters:
- DATABITWIDTH, 16, width of result data
- REGADDRBITWIDTH, 4, register address width (16 registers)
- SOURCECOUNT, 4, number of result sources; must be ≥2
- BUFFERDEPTH, 2, entries per source FIFO; must be a power of two, ≥2

Ports:
- clk  in  1  system clock
- clk_en  in  1  global clock enable; all state advances only when high
- sync_rst  in  1  synchronous active-high reset
- Src_Valid  in  SOURCECOUNT  per-source result valid
- Src_Addr  in  SOURCECOUNT*REGADDRBITWIDTH  per-source destination register, source i at [i*REGADDRBITWIDTH +: REGADDRBITWIDTH]
- Src_Data  in  SOURCECOUNT*DATABITWIDTH  per-source result, source i at [i*DATABITWIDTH +: DATABITWIDTH]
- Src_Ready  out  SOURCECOUNT  per-source FIFO not full
- Write_En  out  1  registered register-file write enable
- Write_Address  out  REGADDRBITWIDTH  registered write address
- Write_Data  out  DATABITWIDTH  registered write data
- Forward1Valid  out  1  equals Write_En
- Forward1RegAddr  out  REGADDRBITWIDTH  equals Write_Address
- Forward1Data  out  DATABITWIDTH  equals Write_Data
- WritebackCongestion  out  1  any source FIFO full (combinational from state)
- WritebackIdle  out  1  all FIFOs empty and Write_En low

Behaviour:
- Clock, reset and enable
  - One clock (clk). Reset is synchronous, active-high (sync_rst).
  - State updates when clk_en || sync_rst; sync_rst has priority.
- Reset values
  - All FIFOs empty; read/write pointers 0; round-robin pointer 0.
  - Write_En=0, Write_Address=0, Write_Data=0.
  - Src_Ready all 1; WritebackCongestion=0; WritebackIdle=1.
- Enqueue
  - Source i enqueues at an enabled edge when Src_Valid[i] && Src_Ready[i].
  - Src_Ready[i] = ~full[i], derived from registered state only. There is no same-cycle dequeue pass-through: a full FIFO refuses input even while being drained.
  - Src_Valid while not ready: data is dropped. Upstream must hold or stall; the bench flags this as a protocol error.
- Arbitration (combinational)
  - Among non-empty FIFOs, grant the first index at or after RRPtr, wrapping modulo SOURCECOUNT.
  - On grant g at an enabled edge: dequeue FIFO g; Write_En<=1, Write_Address/Data<=head of g; RRPtr<=(g+1) mod SOURCECOUNT (wraps SOURCECOUNT-1 → 0).
  - No grant: Write_En<=0, Address/Data hold last values, RRPtr unchanged.
- Latency
  - Entry accepted at edge k reaches Write_En at edge k+1 if it is granted immediately (FIFO was empty and no contention).
  - Worst case is bounded by SOURCECOUNT*BUFFERDEPTH enabled cycles.
- Ordering
  - FIFO order is preserved per source.
  - Cross-source order to the same register is not guaranteed; tagging upstream prevents such WAW hazards.
- Occupancy
  - Per-source occupancy counter, width $clog2(BUFFERDEPTH)+1.
  - Simultaneous enqueue+dequeue on the same FIFO leaves the count unchanged.
  - Full = count==BUFFERDEPTH.
- clk_en low: no enqueue, no dequeue, outputs hold. Src_Ready and WritebackCongestion still reflect current state.
- Reset mid-operation: all pending entries are discarded and Write_En drops at the reset edge.
- Register address 0 is written like any other; there is no special-casing.

Optional Feature:
- Macro: WRITEBACK_FIXED_PRIORITY_EN.
- Defined: RRPtr is removed and the grant always goes to the lowest-index non-empty FIFO. Source 0 (ALU0) then has absolute priority and other sources may starve.
- Undefined: round-robin as above.

Test Plan:
- Reset: assert sync_rst with FIFO 2 holding 1 entry -> next cycle Write_En=0, Src_Ready=4'b1111, WritebackIdle=1, nothing written afterwards.
- Single source: Src_Valid=4'b0001, Addr=3, Data=16'hBEEF for one edge -> Write_En=1, Write_Address=3, Write_Data=16'hBEEF exactly one cycle later, then Write_En=0, WritebackIdle=1.
- Round-robin contention: all four sources valid at once with Data=16'h0A00+i -> writes appear on 4 consecutive cycles in order 0,1,2,3. A second simultaneous burst is then granted starting from source 0 again (RRPtr wrapped 3→0).
- Backpressure: source 1 valid for 4 consecutive edges while sources 0,2,3 are continuously valid -> Src_Ready[1]=0 and WritebackCongestion=1 once 2 entries are queued; no accepted entry is lost; source 1 data is written in FIFO order.
- clk_en gating: load 2 entries, hold clk_en=0 for 5 cycles -> Write_En and all outputs frozen, no dequeue; draining resumes when clk_en=1.
- WRITEBACK_FIXED_PRIORITY_EN defined: sources 0 and 3 continuously valid -> only source 0 is written until it goes idle; then source 3's queued entries are written.
